// File: rtl/multdiv_cycle_downcounter_pkg.sv
// Shared definitions for the multdiv cycle sequencer: FSM state encoding and
// default iteration counts that the multdiv datapath also uses.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam int COUNT_W_DEF     = 6;
  localparam int MULT_CYCLES_DEF = 16;
  localparam int DIV_CYCLES_DEF  = 32;

  // Iteration count for the selected operation.
  function automatic int cycles_for(input logic op_div, input int mult_cycles,
                                    input int div_cycles);
    return op_div ? div_cycles : mult_cycles;
  endfunction

endpackage

// File: rtl/multdiv_cycle_downcounter_if.sv
// Handshake/status bundle between the multdiv operand latches and the cycle sequencer.
// The abort signal exists only when MULTDIV_ABORT_EN is defined.
interface multdiv_cycle_downcounter_if
  import multdiv_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
);

  // start/op_div are level-sampled at posedge; start is accepted only in IDLE or
  // DONE, and op_div matters only in the cycle where start is accepted.
  logic               start;
  logic               op_div;
`ifdef MULTDIV_ABORT_EN
  logic               abort;
`endif
  logic [COUNT_W-1:0] count;
  logic               step;
  logic               last;
  logic               busy;
  logic               done;
  state_t             state;

`ifdef MULTDIV_ABORT_EN
  modport master (
    output start, op_div, abort,
    input  count, step, last, busy, done, state
  );

  modport slave (
    input  start, op_div, abort,
    output count, step, last, busy, done, state
  );
`else
  modport master (
    output start, op_div,
    input  count, step, last, busy, done, state
  );

  modport slave (
    input  start, op_div,
    output count, step, last, busy, done, state
  );
`endif

endinterface

// File: rtl/multdiv_cycle_downcounter_count_reg.sv
// Iteration counter: synchronous clear, parallel load, saturating decrement.
// Exposes its next value so the owner can register flags aligned with it.
module multdiv_count_reg #(
  parameter int COUNT_W = 6
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               dec,
  output logic [COUNT_W-1:0] count_q,
  output logic [COUNT_W-1:0] count_d
);

  // Load wins over decrement; decrement stops at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multdiv_cycle_downcounter.sv
// Down-counting cycle sequencer for the iterative multdiv unit: IDLE -> RUN -> DONE.
// Optional abort input is enabled by defining MULTDIV_ABORT_EN.
module multdiv_cycle_downcounter
  import multdiv_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        clr,
  multdiv_cycle_downcounter_if.slave  bus
);

  state_t             state_q, state_d;
  logic               step_q,  step_d;
  logic               last_q,  last_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               cnt_load;
  logic [COUNT_W-1:0] cnt_load_val;
  logic               cnt_dec;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] op_load_val;
  logic               abort_req;

`ifdef MULTDIV_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Counter holds "remaining iterations minus one", so load N-1.
  assign op_load_val =
    COUNT_W'(cycles_for(bus.op_div, MULT_CYCLES, DIV_CYCLES) - 1);

  multdiv_count_reg #(
    .COUNT_W (COUNT_W)
  ) u_count_reg (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count_q  (count_q),
    .count_d  (count_d)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = op_load_val;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (count_q == '0) begin
            state_d = ST_DONE;
          end
        end
      end

      // Restart straight from DONE keeps back-to-back ops gap-free.
      ST_DONE: begin
        if (abort_req) begin
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          state_d      = ST_IDLE;
        end else if (bus.start) begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_load     = 1'b1;
        cnt_load_val = '0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state/count so they line up with
  // state_q and count_q in the same cycle.
  always_comb begin
    step_d = (state_d == ST_RUN);
    last_d = (state_d == ST_RUN) && (count_d == '0);
    busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      step_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.step  = step_q;
  assign bus.last  = last_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_multdiv_cycle_downcounter.sv
// Directed bench for multdiv_cycle_downcounter (MULT_CYCLES=16, DIV_CYCLES=32);
// abort scenarios are included when MULTDIV_ABORT_EN is defined.
module tb_multdiv_cycle_downcounter;
  import multdiv_pkg::*;

  localparam int CW = 6;
  localparam int NM = 16;
  localparam int ND = 32;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  // {count, step, last, busy, done}
  logic [CW+3:0] obs;
  logic [CW+3:0] exp_v;

  multdiv_cycle_downcounter_if #(.COUNT_W(CW)) bus ();

  multdiv_cycle_downcounter #(
    .COUNT_W     (CW),
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at negedge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
      n_cmp++;
      if (obs !== '0 || bus.state !== ST_IDLE) begin
        n_err++;
        $display("FAIL reset_c%0d: got %h state %0d, want 0 state 0", c, obs, bus.state);
      end
      tick();
    end
  endtask

  task automatic test_mult();
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      exp_v = {CW'(NM - k), 1'b1, (k == NM), 1'b1, 1'b0};
      obs   = {bus.count, bus.step, bus.last, bus.busy, bus.done};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL mult_k%0d: got %h want %h", k, obs, exp_v);
      end
      tick();
    end
    exp_v = {CW'(0), 1'b0, 1'b0, 1'b1, 1'b1};
    obs   = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL mult_done: got %h want %h", obs, exp_v);
    end
    tick();
    obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== '0 || bus.state !== ST_IDLE) begin
      n_err++;
      $display("FAIL mult_idle: got %h state %0d, want 0 state 0", obs, bus.state);
    end
  endtask

  task automatic test_div();
    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    for (int k = 1; k <= ND; k++) begin
      exp_v = {CW'(ND - k), 1'b1, (k == ND), 1'b1, 1'b0};
      obs   = {bus.count, bus.step, bus.last, bus.busy, bus.done};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL div_k%0d: got %h want %h", k, obs, exp_v);
      end
      tick();
    end
    exp_v = {CW'(0), 1'b0, 1'b0, 1'b1, 1'b1};
    obs   = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL div_done: got %h want %h", obs, exp_v);
    end
    tick();
    obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL div_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_start_in_run();
    int steps;
    int dones;
    steps = 0;
    dones = 0;
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= NM + 6; k++) begin
      if (bus.step === 1'b1) steps++;
      if (bus.done === 1'b1) dones++;
      if (k == 5) begin
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
      end else begin
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (steps != NM || dones != 1) begin
      n_err++;
      $display("FAIL ignore_start: got steps=%0d dones=%0d want steps=%0d dones=1", steps, dones, NM);
    end
    obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL ignore_start_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_back_to_back();
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= NM; k++) tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.state !== ST_DONE) begin
      n_err++;
      $display("FAIL b2b_done: got done=%b state=%0d want done=1 state=2", bus.done, bus.state);
    end
    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    for (int k = 1; k <= ND; k++) begin
      exp_v = {CW'(ND - k), 1'b1, (k == ND), 1'b1, 1'b0};
      obs   = {bus.count, bus.step, bus.last, bus.busy, bus.done};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL b2b_k%0d: got %h want %h", k, obs, exp_v);
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done2: got %b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_clr_mid_run();
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    n_cmp++;
    if (bus.count !== CW'(NM - 7)) begin
      n_err++;
      $display("FAIL clr_pre_count: got %0d want %0d", bus.count, NM - 7);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
      n_cmp++;
      if (obs !== '0 || bus.state !== ST_IDLE) begin
        n_err++;
        $display("FAIL clr_mid_c%0d: got %h state %0d, want 0 state 0", c, obs, bus.state);
      end
      tick();
    end
  endtask

`ifdef MULTDIV_ABORT_EN
  task automatic test_abort();
    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== '0 || bus.state !== ST_IDLE) begin
      n_err++;
      $display("FAIL abort_run: got %h state %0d, want 0 state 0", obs, bus.state);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_v = {CW'(NM - 1), 1'b1, 1'b0, 1'b1, 1'b0};
    obs   = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL abort_restart: got %h want %h", obs, exp_v);
    end
    for (int k = 2; k <= NM; k++) tick();
    tick();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    obs = {bus.count, bus.step, bus.last, bus.busy, bus.done};
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL abort_done_prio: got %h want 0", obs);
    end
  endtask
`endif

  initial begin
    clr        = 1'b1;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
`ifdef MULTDIV_ABORT_EN
    bus.abort  = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_start_in_run();
    test_back_to_back();
    test_clr_mid_run();
`ifdef MULTDIV_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
